// File: rtl/controlador_banco.sv
// rtl/controlador_banco.sv - command sequencer for the 4-entry register bank (optional flags: STATUS_FLAGS_EN)
module controlador_banco #(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [1:0]      cmd_dst,
  input  logic [1:0]      cmd_src1,
  input  logic [1:0]      cmd_src2,
  input  logic [Size-1:0] cmd_imm,
  output logic            done,
  output logic [Size-1:0] result,
  output logic            flag_z,
  output logic            flag_c,
  output logic            we,
  output logic [1:0]      a1,
  output logic [1:0]      a2,
  output logic [Size-1:0] wd,
  input  logic [Size-1:0] rd1,
  input  logic [Size-1:0] rd2
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [1:0]      dst_q, src1_q, src2_q;
  logic [Size-1:0] imm_q, op1_q, op2_q;
  logic [Size-1:0] value;
  logic            fire;
  logic            writing;

  assign fire    = cmd_valid & cmd_ready;
  assign writing = (op_q != OP_NOP);

  // Value to be written in WRITE, from the latched command and captured operands
  always_comb begin
    value = '0;
    case (op_q)
      OP_LOAD: value = imm_q;
      OP_MOV:  value = op1_q;
      OP_ADD:  value = op1_q + op2_q;
      OP_SUB:  value = op1_q - op2_q;
      OP_AND:  value = op1_q & op2_q;
      OP_OR:   value = op1_q | op2_q;
      OP_XOR:  value = op1_q ^ op2_q;
      default: value = '0;
    endcase
  end

  // Bank-side outputs decoded from state; everything is forced quiet while clr is high
  always_comb begin
    cmd_ready = 1'b0;
    we        = 1'b0;
    done      = 1'b0;
    a1        = 2'd0;
    a2        = 2'd0;
    wd        = '0;
    if (!clr) begin
      case (state)
        IDLE: cmd_ready = 1'b1;
        READ: begin
          a1 = src1_q;
          a2 = src2_q;
        end
        WRITE: begin
          a1   = dst_q;
          wd   = value;
          we   = writing;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequencer: latch on handshake, capture operands in READ, commit result in WRITE
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            op_q   <= cmd_op;
            dst_q  <= cmd_dst;
            src1_q <= cmd_src1;
            src2_q <= cmd_src2;
            imm_q  <= cmd_imm;
            state  <= (cmd_op == OP_LOAD || cmd_op == OP_NOP) ? WRITE : READ;
          end
        end
        READ: begin
          op1_q <= rd1;
          op2_q <= rd2;
          state <= WRITE;
        end
        WRITE: begin
          if (writing) result <= value;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STATUS_FLAGS_EN
  logic carry;

  // Carry-out of ADD, borrow of SUB (op1 < op2 unsigned); other ops clear it
  always_comb begin
    carry = 1'b0;
    if (op_q == OP_ADD)      carry = ({1'b0, op1_q} + {1'b0, op2_q}) > {1'b0, {Size{1'b1}}};
    else if (op_q == OP_SUB) carry = (op1_q < op2_q);
  end

  // Flags follow the committed write; NOP leaves them alone
  always_ff @(posedge clk) begin
    if (clr) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (state == WRITE && writing) begin
      flag_z <= (value == '0);
      flag_c <= carry;
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule
